push_button_conditioner: RTL and testbench

//  Front end for the lock FSM. Turns the two raw push buttons PB_1/PB_0 into clean,

---
 rtl/push_button_conditioner.sv | 152 +++++++++++++++
 tb/tb_push_button_conditioner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/push_button_conditioner.sv
// push_button_conditioner: synchronizes two raw push buttons, debounces them on a shared
// prescaler tick, and emits one-cycle press events plus debounced levels.
module push_button_conditioner #(
  parameter int unsigned DIV_WIDTH    = 19,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PB_1,
  input  logic       PB_0,
  output logic       Tick,
  output logic [1:0] Input,
  output logic [1:0] Level
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(STABLE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   LP_DIRECT   = (STABLE_TICKS <= 1);

  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_tick;
  logic [1:0]           r_s1;
  logic [1:0]           r_s2;
  logic [1:0]           w_pb;

  assign w_pb = {PB_1, PB_0};
  assign Tick = r_tick;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_pb;
      r_s2 <= r_s1;
    end
  end

  // Tick is registered, so it lands in the cycle after the counter reads all-ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= r_div + DIV_WIDTH'(1);
      r_tick <= (r_div == '1);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_btn
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_lvl;
    logic                 w_lvl_nxt;
    logic                 r_press;
    logic                 w_press_nxt;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        r_state <= IDLE_LO;
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
        r_press <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_lvl   <= w_lvl_nxt;
        r_press <= w_press_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lvl_nxt   = r_lvl;
      w_press_nxt = 1'b0;
      if (r_tick) begin
        case (r_state)
          IDLE_LO: begin
            if (r_s2[g]) begin
              // A single required sample accepts the new level without a WAIT state.
              if (LP_DIRECT) begin
                w_state_nxt = IDLE_HI;
                w_cnt_nxt   = '0;
                w_lvl_nxt   = 1'b1;
                w_press_nxt = 1'b1;
              end else begin
                w_state_nxt = WAIT_HI;
                w_cnt_nxt   = LP_CNT_ONE;
              end
            end
          end
          WAIT_HI: begin
            if (!r_s2[g]) begin
              w_state_nxt = IDLE_LO;
              w_cnt_nxt   = '0;
            end else if (r_cnt == LP_CNT_LAST) begin
              w_state_nxt = IDLE_HI;
              w_cnt_nxt   = '0;
              w_lvl_nxt   = 1'b1;
              w_press_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
          end
          IDLE_HI: begin
            if (!r_s2[g]) begin
              if (LP_DIRECT) begin
                w_state_nxt = IDLE_LO;
                w_cnt_nxt   = '0;
                w_lvl_nxt   = 1'b0;
              end else begin
                w_state_nxt = WAIT_LO;
                w_cnt_nxt   = LP_CNT_ONE;
              end
            end
          end
          WAIT_LO: begin
            if (r_s2[g]) begin
              w_state_nxt = IDLE_HI;
              w_cnt_nxt   = '0;
            end else if (r_cnt == LP_CNT_LAST) begin
              w_state_nxt = IDLE_LO;
              w_cnt_nxt   = '0;
              w_lvl_nxt   = 1'b0;
            end else begin
              w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign Input[g] = r_press;
    assign Level[g] = r_lvl;
  end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner (Tick every 8 cycles, 3 stable samples);
// expected press events are queued when buttons are driven and matched by a monitor.
module tb_push_button_conditioner;

  localparam int PER = 8;
  localparam int ST  = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PB_1  = 1'b0;
  logic       PB_0  = 1'b0;
  logic       Tick;
  logic [1:0] Input;
  logic [1:0] Level;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
    logic [1:0] lvl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_it;

  push_button_conditioner #(
    .DIV_WIDTH   (3),
    .STABLE_TICKS(ST),
    .CNT_WIDTH   (2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .PB_1 (PB_1),
    .PB_0 (PB_0),
    .Tick (Tick),
    .Input(Input),
    .Level(Level)
  );

  always #5 Clock = ~Clock;

  // Edge count since reset release; cyc == k right after the k-th posedge.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Edge whose output cycle carries the event for a level driven right after edge c.
  function automatic int exp_edge(input int c);
    int e;
    e = c + 3;
    while (e % PER != 1 || e < PER + 1) e++;
    return e + PER * (ST - 1);
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    int guard;
    guard = 0;
    while (cyc != t && guard < 2000) begin
      step();
      guard++;
    end
    if (cyc != t) chk("wait_until_timeout", cyc, t);
  endtask

  task automatic align();
    int guard;
    guard = 0;
    step();
    while ((cyc % PER != 1 || cyc < PER + 1) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("align_timeout", cyc % PER, 1);
  endtask

  task automatic push_exp(input int e, input logic [1:0] v, input logic [1:0] l);
    exp_t it;
    it.cyc = e;
    it.val = v;
    it.lvl = l;
    exp_q.push_back(it);
  endtask

  always @(negedge Clock) begin
    chk("tick", 32'(Tick), 32'(cyc >= PER && cyc % PER == 0));
    if (Input != 2'b00 || (exp_q.size() > 0 && cyc == exp_q[0].cyc)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_input", 32'(Input), 32'(0));
      end else begin
        mon_it = exp_q.pop_front();
        chk("press_val", 32'(Input), 32'(mon_it.val));
        chk("press_cyc", cyc, mon_it.cyc);
        chk("press_lvl", 32'(Level), 32'(mon_it.lvl));
      end
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    int c;
    int e;
    int f;

    // 1: reset held with toggling buttons
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge Clock);
      PB_0 = ~PB_0;
      PB_1 = 1'($urandom_range(0, 1));
      #1;
      chk("rst_tick", 32'(Tick), 32'(0));
      chk("rst_input", 32'(Input), 32'(0));
      chk("rst_level", 32'(Level), 32'(0));
    end
    @(negedge Clock);
    PB_0 = 1'b0;
    PB_1 = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    wait_until(7);
    chk("first_tick_pre", 32'(Tick), 32'(0));
    step();
    chk("first_tick", 32'(Tick), 32'(1));
    step();
    chk("tick_width", 32'(Tick), 32'(0));
    wait_until(16);
    chk("second_tick", 32'(Tick), 32'(1));

    // 2: clean press of PB_0
    align();
    c    = cyc;
    PB_0 = 1'b1;
    e    = exp_edge(c);
    push_exp(e, 2'b01, 2'b01);
    wait_until(e - 1);
    chk("level_before_press", 32'(Level), 32'(0));
    wait_until(e + 5 * PER);
    chk("level_held", 32'(Level), 32'(1));
    chk("press_consumed", exp_q.size(), 0);
    c    = cyc;
    PB_0 = 1'b0;
    e    = exp_edge(c);
    wait_until(e - 1);
    chk("release_pre", 32'(Level), 32'(1));
    step();
    chk("release_done", 32'(Level), 32'(0));

    // 3: bounce 1,0,1 on successive ticks, then stable
    align();
    PB_0 = 1'b1;
    repeat (PER) step();
    PB_0 = 1'b0;
    repeat (PER) step();
    c    = cyc;
    PB_0 = 1'b1;
    e    = exp_edge(c);
    push_exp(e, 2'b01, 2'b01);
    wait_until(e + 2 * PER);
    chk("bounce_level", 32'(Level), 32'(1));
    c    = cyc;
    PB_0 = 1'b0;
    e    = exp_edge(c);
    wait_until(e + 1);
    chk("bounce_release", 32'(Level), 32'(0));

    // 4: simultaneous press, then simultaneous silent release
    align();
    c    = cyc;
    PB_0 = 1'b1;
    PB_1 = 1'b1;
    e    = exp_edge(c);
    push_exp(e, 2'b11, 2'b11);
    wait_until(e + 2 * PER);
    chk("both_level", 32'(Level), 32'(3));
    c    = cyc;
    PB_0 = 1'b0;
    PB_1 = 1'b0;
    e    = exp_edge(c);
    wait_until(e - 1);
    chk("both_release_pre", 32'(Level), 32'(3));
    step();
    chk("both_release", 32'(Level), 32'(0));

    // 5: reset during the second stable tick of a PB_1 press
    align();
    c    = cyc;
    PB_0 = 1'b1;
    e    = exp_edge(c);
    push_exp(e, 2'b01, 2'b01);
    wait_until(e + 1);
    align();
    c    = cyc;
    PB_1 = 1'b1;
    f    = c + PER;
    wait_until(f + PER - 1);
    chk("pre_reset_tick", 32'(Tick), 32'(1));
    chk("pre_reset_level", 32'(Level), 32'(1));
    #1;
    Reset = 1'b1;
    #1;
    chk("async_tick", 32'(Tick), 32'(0));
    chk("async_input", 32'(Input), 32'(0));
    chk("async_level", 32'(Level), 32'(0));
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    e = exp_edge(0);
    push_exp(e, 2'b11, 2'b11);
    wait_until(e + 1);

    // 6: glitches that fall between tick samples
    align();
    PB_0 = 1'b0;
    repeat (4) step();
    PB_0 = 1'b1;
    repeat (4 * PER) step();
    chk("glitch_low_level", 32'(Level), 32'(3));
    c    = cyc;
    PB_0 = 1'b0;
    PB_1 = 1'b0;
    e    = exp_edge(c);
    wait_until(e + 1);
    chk("final_release", 32'(Level), 32'(0));
    align();
    PB_1 = 1'b1;
    repeat (4) step();
    PB_1 = 1'b0;
    repeat (4 * PER) step();
    chk("glitch_high_level", 32'(Level), 32'(0));

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
